systolic_operand_sequencer: RTL

Tile-level operand sequencer sitting directly upstream of the systolic input skew stage. On a `start` command it reads operand vectors from two synchronous-read operand buffers (A buffer, B buffer) and drives the skew stage's `enable`, `load`, `data_flow`, `A`, `B` inputs with correctly phased, unskewed vectors. It supports OS mode (A and B streamed together) and WS mode (weight preload from B, then A streaming), then waits out the array drain and reports completion.

---
 rtl/systolic_pkg.sv | 19 +
 rtl/systolic_operand_sequencer_if.sv | 36 +++
 rtl/operand_read_pipe.sv | 33 +++
 rtl/systolic_operand_sequencer.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic operand sequencer.
package systolic_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StStream,
    StDrain
  } state_e;

  localparam logic MODE_OS = 1'b0;
  localparam logic MODE_WS = 1'b1;

  // Cycles the array needs to flush after the last enabled vector.
  function automatic int unsigned drain_cycles(int unsigned rows, int unsigned cols);
    return rows + cols;
  endfunction

endpackage

// File: rtl/systolic_operand_sequencer_if.sv
// Command, operand-buffer read and skew-stage signals of the operand sequencer.
interface systolic_operand_sequencer_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ROWS       = 8,
  parameter int unsigned COLS       = 8,
  parameter int unsigned ADDR_WIDTH = 8
) ();

  logic                       start;
  logic                       mode;
  logic [ADDR_WIDTH:0]        k_len;
  logic                       busy;
  logic                       done;
  logic                       a_rd_en;
  logic [ADDR_WIDTH-1:0]      a_rd_addr;
  logic [ROWS*DATA_WIDTH-1:0] a_rd_data;
  logic                       b_rd_en;
  logic [ADDR_WIDTH-1:0]      b_rd_addr;
  logic [COLS*DATA_WIDTH-1:0] b_rd_data;
  logic                       enable;
  logic                       load;
  logic                       data_flow;
  logic [ROWS*DATA_WIDTH-1:0] a;
  logic [COLS*DATA_WIDTH-1:0] b;

  modport master (
    output start, mode, k_len, a_rd_data, b_rd_data,
    input  busy, done, a_rd_en, a_rd_addr, b_rd_en, b_rd_addr, enable, load, data_flow, a, b
  );

  modport slave (
    input  start, mode, k_len, a_rd_data, b_rd_data,
    output busy, done, a_rd_en, a_rd_addr, b_rd_en, b_rd_addr, enable, load, data_flow, a, b
  );

endinterface

// File: rtl/operand_read_pipe.sv
// Tracks a synchronous-read buffer access and registers the returned vector;
// the output is zero whenever no read result is being presented.
module operand_read_pipe #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_rd_en,
  input  logic [WIDTH-1:0] i_rd_data,
  output logic             o_vld,
  output logic [WIDTH-1:0] o_data
);

  logic             r_rd_pend;
  logic             r_vld;
  logic [WIDTH-1:0] r_data;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_pend <= 1'b0;
      r_vld     <= 1'b0;
      r_data    <= '0;
    end else begin
      r_rd_pend <= i_rd_en;
      r_vld     <= r_rd_pend;
      r_data    <= r_rd_pend ? i_rd_data : '0;
    end
  end

  assign o_vld  = r_vld;
  assign o_data = r_data;

endmodule

// File: rtl/systolic_operand_sequencer.sv
// Reads A/B operand buffers on a start command and drives the systolic skew stage
// with phased enable/load/data; OS streams A and B together, WS preloads B first.
module systolic_operand_sequencer
  import systolic_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ROWS       = 8,
  parameter int unsigned COLS       = 8,
  parameter int unsigned K_MAX      = 256,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input logic                       i_clk,
  input logic                       i_rst_n,
  systolic_operand_sequencer_if.slave if_seq
);

  // Drain is counted from the last read, so it also covers the 2-cycle read-to-output latency.
  localparam int unsigned DRAIN_LAST = drain_cycles(ROWS, COLS) + 2;
  localparam int unsigned CNT_MAX_0  = (K_MAX > ROWS) ? K_MAX : ROWS;
  localparam int unsigned CNT_MAX    = (CNT_MAX_0 > DRAIN_LAST) ? CNT_MAX_0 : DRAIN_LAST;
  localparam int unsigned CNT_W      = $clog2(CNT_MAX + 1);
  localparam logic [ADDR_WIDTH:0] K_SAT = (ADDR_WIDTH + 1)'(K_MAX);

  state_e                     r_state, w_state_d;
  logic [CNT_W-1:0]           r_cnt, w_cnt_d;
  logic [ADDR_WIDTH:0]        r_k_len, w_k_sat;
  logic                       r_busy, r_done, r_load, r_data_flow;
  logic                       r_a_rd_en, r_b_rd_en, r_b_rd_q;
  logic [ADDR_WIDTH-1:0]      r_rd_addr;
  logic                       w_accept, w_ws_d, w_a_rd_en_d, w_b_rd_en_d;
  logic                       w_a_vld, w_b_vld;
  logic [ROWS*DATA_WIDTH-1:0] w_a_data;
  logic [COLS*DATA_WIDTH-1:0] w_b_data;

  assign w_accept = if_seq.start & ~r_busy;
  assign w_k_sat  = (if_seq.k_len > K_SAT) ? K_SAT : if_seq.k_len;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
    end
  end

  // LOAD spends ROWS read cycles plus one idle cycle before A streaming starts.
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_cnt_d = '0;
          if (if_seq.mode == MODE_WS)  w_state_d = StLoad;
          else if (w_k_sat == '0)      w_state_d = StDrain;
          else                         w_state_d = StStream;
        end
      end
      StLoad: begin
        if (r_cnt == CNT_W'(ROWS)) begin
          w_cnt_d   = '0;
          w_state_d = (r_k_len == '0) ? StDrain : StStream;
        end else begin
          w_cnt_d = r_cnt + CNT_W'(1);
        end
      end
      StStream: begin
        if (r_cnt + CNT_W'(1) == CNT_W'(r_k_len)) begin
          w_cnt_d   = '0;
          w_state_d = StDrain;
        end else begin
          w_cnt_d = r_cnt + CNT_W'(1);
        end
      end
      StDrain: begin
        if (r_cnt == CNT_W'(DRAIN_LAST)) begin
          w_cnt_d   = '0;
          w_state_d = StIdle;
        end else begin
          w_cnt_d = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_cnt_d   = '0;
        w_state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    w_ws_d      = w_accept ? if_seq.mode : r_data_flow;
    w_a_rd_en_d = (w_state_d == StStream);
    w_b_rd_en_d = ((w_state_d == StStream) && (w_ws_d == MODE_OS)) ||
                  ((w_state_d == StLoad) && (w_cnt_d < CNT_W'(ROWS)));
  end

  // Read ports are registered from next-state so address i appears in the cycle counted as i.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_k_len     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_a_rd_en   <= 1'b0;
      r_b_rd_en   <= 1'b0;
      r_rd_addr   <= '0;
      r_data_flow <= 1'b0;
      r_b_rd_q    <= 1'b0;
      r_load      <= 1'b0;
    end else begin
      if (w_accept) r_k_len <= w_k_sat;
      r_busy      <= (w_state_d != StIdle);
      r_done      <= (w_state_d == StDrain) && (w_cnt_d == CNT_W'(DRAIN_LAST));
      r_a_rd_en   <= w_a_rd_en_d;
      r_b_rd_en   <= w_b_rd_en_d;
      r_rd_addr   <= (w_a_rd_en_d | w_b_rd_en_d) ? w_cnt_d[ADDR_WIDTH-1:0] : '0;
      r_data_flow <= w_ws_d;
      r_b_rd_q    <= r_b_rd_en;
      // Stretch load one cycle past the last weight for the skew stage's bypass register.
      r_load      <= r_data_flow & (r_b_rd_q | w_b_vld);
    end
  end

  operand_read_pipe #(
    .WIDTH(ROWS * DATA_WIDTH)
  ) u_a_pipe (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_rd_en  (r_a_rd_en),
    .i_rd_data(if_seq.a_rd_data),
    .o_vld    (w_a_vld),
    .o_data   (w_a_data)
  );

  operand_read_pipe #(
    .WIDTH(COLS * DATA_WIDTH)
  ) u_b_pipe (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_rd_en  (r_b_rd_en),
    .i_rd_data(if_seq.b_rd_data),
    .o_vld    (w_b_vld),
    .o_data   (w_b_data)
  );

  assign if_seq.busy      = r_busy;
  assign if_seq.done      = r_done;
  assign if_seq.a_rd_en   = r_a_rd_en;
  assign if_seq.a_rd_addr = r_rd_addr;
  assign if_seq.b_rd_en   = r_b_rd_en;
  assign if_seq.b_rd_addr = r_rd_addr;
  assign if_seq.enable    = w_a_vld;
  assign if_seq.load      = r_load;
  assign if_seq.data_flow = r_data_flow;
  assign if_seq.a         = w_a_data;
  assign if_seq.b         = w_b_data;

endmodule
